// File: rtl/branch_resolve_unit.sv
// ============================================================================
// branch_resolve_unit
// ----------------------------------------------------------------------------
// Resolves RV32I control-transfer ops (BRANCH / JAL / JALR) handed over by
// decode/ALU issue. A jump, or any op that turns out to be illegal, resolves
// straight from the issue inputs. A conditional branch waits one cycle so the
// ALU can register the RS1-RS2 compare flags, and then resolves from those
// flags. The result sits in registers until the fetch-redirect / writeback
// consumer takes it. Only one op is in flight at a time.
//
// Ports
//   clk        in   1        clock, all state on the rising edge
//   rst        in   1        asynchronous, active-high reset
//   br_valid   in   1        op presented
//   br_ready   out  1        unit can accept an op (high only when idle)
//   opcode     in   7        1100011 BRANCH, 1101111 JAL, 1100111 JALR
//   funct3     in   3        branch condition
//   pc         in   N        PC of the op
//   offset     in   N        sign-extended B/J/I immediate
//   rs1_data   in   N        JALR base register value
//   flag_reg   in   FLAG_W   registered ALU flags {N,Z,C,V}, C=1 means no borrow
//   res_valid  out  1        result held valid
//   res_ready  in   1        consumer accepts the result
//   taken      out  1        control transfer occurs
//   next_pc    out  N        redirect target when taken, otherwise PC+4
//   link_we    out  1        JAL/JALR writes rd
//   link_data  out  N        PC+4
//   misalign   out  1        taken target not word aligned
//   illegal    out  1        unknown opcode, or BRANCH with funct3 010/011
//   stat_br    out  32       branches resolved  (only with BRU_STATS_EN)
//   stat_tk    out  32       branches taken     (only with BRU_STATS_EN)
//
// Build option
//   BRU_STATS_EN  when defined, adds the stat_br / stat_tk counters and ports.
// ============================================================================
module branch_resolve_unit #(
    parameter int N      = 32,
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [N-1:0]      pc,
    input  logic [N-1:0]      offset,
    input  logic [N-1:0]      rs1_data,
    input  logic [FLAG_W-1:0] flag_reg,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              taken,
    output logic [N-1:0]      next_pc,
    output logic              link_we,
    output logic [N-1:0]      link_data,
    output logic              misalign,
    output logic              illegal
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]       stat_br,
    output logic [31:0]       stat_tk
`endif
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FLAGS,
        DONE
    } state_t;

    state_t state;

    // Branch fields held across the flag-wait cycle; the issue inputs are
    // free to change once the op has been accepted.
    logic [N-1:0] cap_pc;
    logic [N-1:0] cap_offset;
    logic [2:0]   cap_funct3;

    // Operand sources for the resolver.
    logic         sel_wait;
    logic [6:0]   src_opcode;
    logic [2:0]   src_funct3;
    logic [N-1:0] src_pc;
    logic [N-1:0] src_offset;

    logic         is_branch;
    logic         is_jal;
    logic         is_jalr;
    logic         is_legal;
    logic         cond_true;
    logic         wants_transfer;
    logic [N-1:0] base;
    logic [N-1:0] sum;
    logic [N-1:0] target;
    logic [N-1:0] seq_pc;

    logic         r_taken;
    logic [N-1:0] r_next_pc;
    logic         r_link_we;
    logic         r_misalign;
    logic         r_illegal;

    logic         accept;
    logic         load_result;

    // Resolver. While waiting for flags only a captured branch can be in
    // flight, so the opcode is forced to BRANCH and the captured fields are
    // used. In IDLE the live issue inputs are used; that path only ever loads
    // a result for jumps and illegal ops, so a JALR base never needs capturing.
    always_comb begin
        sel_wait   = (state == WAIT_FLAGS);
        src_opcode = sel_wait ? OP_BRANCH  : opcode;
        src_funct3 = sel_wait ? cap_funct3 : funct3;
        src_pc     = sel_wait ? cap_pc     : pc;
        src_offset = sel_wait ? cap_offset : offset;

        is_branch = (src_opcode == OP_BRANCH);
        is_jal    = (src_opcode == OP_JAL);
        is_jalr   = (src_opcode == OP_JALR);
        is_legal  = (is_branch && (src_funct3 != 3'b010) && (src_funct3 != 3'b011))
                    || is_jal || is_jalr;

        // flag_reg = {N, Z, C, V}
        cond_true = 1'b0;
        case (src_funct3)
            3'b000:  cond_true = flag_reg[2];
            3'b001:  cond_true = ~flag_reg[2];
            3'b100:  cond_true = flag_reg[3] ^ flag_reg[0];
            3'b101:  cond_true = ~(flag_reg[3] ^ flag_reg[0]);
            3'b110:  cond_true = ~flag_reg[1];
            3'b111:  cond_true = flag_reg[1];
            default: cond_true = 1'b0;
        endcase

        base   = is_jalr ? rs1_data : src_pc;
        sum    = base + src_offset;
        target = is_jalr ? {sum[N-1:1], 1'b0} : sum;
        seq_pc = src_pc + N'(4);

        wants_transfer = is_jal || is_jalr || (is_branch && cond_true);

        // A transfer to a non word-aligned target is suppressed and flagged
        // instead; the op then behaves as a fall-through with no link write.
        r_misalign = is_legal && wants_transfer && (target[1:0] != 2'b00);
        r_taken    = is_legal && wants_transfer && !r_misalign;
        r_next_pc  = r_taken ? target : seq_pc;
        r_link_we  = is_legal && (is_jal || is_jalr) && !r_misalign;
        r_illegal  = !is_legal;

        accept      = (state == IDLE) && br_valid;
        load_result = (accept && !(is_branch && is_legal)) || sel_wait;
    end

    // Control FSM with all handshake and result outputs registered.
    // A legal branch detours through WAIT_FLAGS so that the flags registered
    // by the ALU on the accept edge are sampled on the following edge.
    // Retiring drops back to IDLE without accepting in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            br_ready   <= 1'b1;
            res_valid  <= 1'b0;
            taken      <= 1'b0;
            next_pc    <= '0;
            link_we    <= 1'b0;
            link_data  <= '0;
            misalign   <= 1'b0;
            illegal    <= 1'b0;
            cap_pc     <= '0;
            cap_offset <= '0;
            cap_funct3 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        br_ready   <= 1'b0;
                        cap_pc     <= pc;
                        cap_offset <= offset;
                        cap_funct3 <= funct3;
                        if (is_branch && is_legal) begin
                            state <= WAIT_FLAGS;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                WAIT_FLAGS: begin
                    state <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        br_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                    br_ready  <= 1'b1;
                end
            endcase

            if (load_result) begin
                res_valid <= 1'b1;
                taken     <= r_taken;
                next_pc   <= r_next_pc;
                link_we   <= r_link_we;
                link_data <= seq_pc;
                misalign  <= r_misalign;
                illegal   <= r_illegal;
            end
        end
    end

`ifdef BRU_STATS_EN
    // Only well-formed, aligned conditional branches are counted; the
    // decision is latched with the result and applied when it retires.
    logic r_counted;
    logic counted;

    always_comb begin
        r_counted = is_branch && is_legal && !r_misalign;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counted <= 1'b0;
            stat_br <= '0;
            stat_tk <= '0;
        end else begin
            if (load_result) begin
                counted <= r_counted;
            end
            if ((state == DONE) && res_ready && counted) begin
                stat_br <= stat_br + 32'd1;
                if (taken) begin
                    stat_tk <= stat_tk + 32'd1;
                end
            end
        end
    end
`endif

endmodule
